mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, memory access-phase length in clocks; legal range 1..15.
REQ-002 Clk  in  1  system clock; all state updates on the rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 Req  in  1  transaction request from the datapath.
REQ-005 WE  in  1  operation select, sampled with Req: 1=write, 0=read.
REQ-006 Addr  in  16  transaction address, sampled on accept.
REQ-007 WData  in  16  write data, sampled on accept when WE=1.
REQ-008 Ready  out  1  high only in IDLE; request accepted at an edge where Req=1 and Ready=1.
REQ-009 Done  out  1  one-cycle completion pulse.
REQ-010 RData  out  16  always equals MDR; read data valid while Done=1 after a read.
REQ-011 Mem_Addr  out  16  always equals MAR.
REQ-012 Mem_WData  out  16  always equals MDR.
REQ-013 Mem_RData  in  16  memory read data.
REQ-014 Mem_CE_N, Mem_OE_N, Mem_WE_N  out  1 each  active-low memory strobes.

Function
REQ-015 States SHALL be IDLE, ACCESS, RECOVER, DONE.
REQ-016 IDLE: Ready=1, all strobes 1; on Req=1, MAR<=Addr, MDR<=WData if WE=1 (MDR unchanged if WE=0), latch WE, counter<=0, go ACCESS.
REQ-017 ACCESS: Ready=0; Mem_CE_N=0; read: Mem_OE_N=0, Mem_WE_N=1; write: Mem_WE_N=0, Mem_OE_N=1; occupies exactly WAIT_CYCLES cycles, counter increments each edge.
REQ-018 Last ACCESS edge, read: MDR<=Mem_RData, go DONE; write: go RECOVER.
REQ-019 RECOVER (write only): one cycle, Mem_CE_N=0, Mem_WE_N=1, Mem_OE_N=1, MAR/MDR held; then DONE.
REQ-020 DONE: one cycle, Done=1, all strobes 1, Ready=0; then IDLE unconditionally.
REQ-021 Latency from accept edge k: read Done high during cycle after edge k+WAIT_CYCLES; write after edge k+WAIT_CYCLES+1.
REQ-022 Req outside IDLE SHALL be ignored; no queuing; Addr/WData/WE changes after accept SHALL have no effect.
REQ-023 Req held continuously: next transaction accepted at the first edge in IDLE (one Ready cycle between transactions).
REQ-024 Mem_OE_N and Mem_WE_N SHALL never be 0 simultaneously; strobes driven from registered state only (glitch-free).
REQ-025 Counter SHALL be 4 bits, never wrap within a transaction.

Reset
REQ-026 Reset=1 SHALL immediately, without a clock edge, force state IDLE, counter 0, MAR=MDR=16'h0000, strobes 1, Done=0, Ready=1.
REQ-027 Reset mid-transaction SHALL abort it with no Done pulse; first accept possible at the first edge after Reset deasserts.

Structure
REQ-028 Shared package mem_ctrl_pkg SHALL hold the state enum typedef, DATA_W=16, and WAIT_CYCLES_DEFAULT=2.
REQ-029 One sub-module, reg_16_ar (16-bit load register, asynchronous active-high reset), SHALL be instanced twice for MAR and MDR.

Verification (WAIT_CYCLES=2 unless noted)
REQ-030 Reset pulse, no Req -> Ready=1, Done=0, all strobes 1, Mem_Addr=RData=16'h0000.
REQ-031 Read Addr=16'h0042, Mem_RData=16'hBEEF -> CE_N=OE_N=0 exactly 2 cycles, Mem_Addr=16'h0042, Done one cycle, RData=16'hBEEF.
REQ-032 Write Addr=16'h1234, WData=16'hA5A5 -> WE_N=0 exactly 2 cycles, OE_N=1 throughout, Mem_WData=16'hA5A5 through RECOVER, Done 3 cycles after accept.
REQ-033 Req held high, Addr changed to 16'hFFFF during ACCESS -> Mem_Addr unchanged, second transaction accepted only after one IDLE cycle.
REQ-034 Reset asserted mid-write ACCESS -> WE_N/CE_N return to 1 before next edge, no Done, Ready=1 after release.
REQ-035 WAIT_CYCLES=1 read -> OE_N low 1 cycle, Done in cycle after edge k+1.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
// Holds the controller state enum, the data width and the default access length.
package mem_ctrl_pkg;

  localparam int DATA_W              = 16;
  localparam int CNT_W               = 4;
  localparam int WAIT_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RECOVER,
    DONE
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Datapath request bus and external memory bus of the access controller.
// master: datapath/memory side; slave: the controller.
interface mem_access_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              Req;
  logic              WE;
  logic [DATA_W-1:0] Addr;
  logic [DATA_W-1:0] WData;
  logic              Ready;
  logic              Done;
  logic [DATA_W-1:0] RData;
  logic [DATA_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_WData;
  logic [DATA_W-1:0] Mem_RData;
  logic              Mem_CE_N;
  logic              Mem_OE_N;
  logic              Mem_WE_N;

  modport master (
    output Req, WE, Addr, WData, Mem_RData,
    input  Ready, Done, RData, Mem_Addr, Mem_WData,
    input  Mem_CE_N, Mem_OE_N, Mem_WE_N
  );

  modport slave (
    input  Req, WE, Addr, WData, Mem_RData,
    output Ready, Done, RData, Mem_Addr, Mem_WData,
    output Mem_CE_N, Mem_OE_N, Mem_WE_N
  );

endinterface

// File: rtl/reg_16_ar.sv
// 16-bit load-enable register with asynchronous active-high reset to zero.
// Ports: clk_i, rst_i, ld_i (load enable), d_i (data in), q_o (register value).
module reg_16_ar
  import mem_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q <= '0;
    end else if (ld_i) begin
      r_q <= d_i;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-transaction memory access controller: IDLE->ACCESS->(RECOVER)->DONE.
// Ports: Clk, Reset (async, active-high), bus (slave modport: request + memory).
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  mem_access_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              wen_q, wen_d;
  logic              mar_ld, mdr_ld;
  logic [DATA_W-1:0] mdr_in;
  logic [DATA_W-1:0] mar_q, mdr_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      wen_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      wen_q   <= wen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    mar_ld  = 1'b0;
    mdr_ld  = 1'b0;
    mdr_in  = bus.WData;
    unique case (state_q)
      IDLE: begin
        if (bus.Req) begin
          state_d = ACCESS;
          cnt_d   = '0;
          we_d    = bus.WE;
          mar_ld  = 1'b1;
          mdr_ld  = bus.WE;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          if (we_q) begin
            state_d = RECOVER;
          end else begin
            state_d = DONE;
            mdr_ld  = 1'b1;
            mdr_in  = bus.Mem_RData;
          end
        end
      end
      RECOVER: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they leave flops glitch-free.
  always_comb begin
    ce_n_d = !(state_d == ACCESS || state_d == RECOVER);
    oe_n_d = !(state_d == ACCESS && !we_d);
    wen_d  = !(state_d == ACCESS && we_d);
  end

  reg_16_ar u_mar (
    .clk_i (Clk),
    .rst_i (Reset),
    .ld_i  (mar_ld),
    .d_i   (bus.Addr),
    .q_o   (mar_q)
  );

  reg_16_ar u_mdr (
    .clk_i (Clk),
    .rst_i (Reset),
    .ld_i  (mdr_ld),
    .d_i   (mdr_in),
    .q_o   (mdr_q)
  );

  assign bus.Ready     = (state_q == IDLE);
  assign bus.Done      = (state_q == DONE);
  assign bus.RData     = mdr_q;
  assign bus.Mem_WData = mdr_q;
  assign bus.Mem_Addr  = mar_q;
  assign bus.Mem_CE_N  = ce_n_q;
  assign bus.Mem_OE_N  = oe_n_q;
  assign bus.Mem_WE_N  = wen_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES 2 and 1) share stimulus.
// A transaction-phase model is compared every cycle; literals pin key points.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic we = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] mrdata = '0;
  logic chk_en = 1'b0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_ctrl_if if0();
  mem_access_ctrl_if if1();

  assign if0.Req = req;
  assign if0.WE = we;
  assign if0.Addr = addr;
  assign if0.WData = wdata;
  assign if0.Mem_RData = mrdata;
  assign if1.Req = req;
  assign if1.WE = we;
  assign if1.Addr = addr;
  assign if1.WData = wdata;
  assign if1.Mem_RData = mrdata;

  mem_access_ctrl #(.WAIT_CYCLES(2)) dut0 (
    .Clk(clk), .Reset(rst), .bus(if0)
  );
  mem_access_ctrl #(.WAIT_CYCLES(1)) dut1 (
    .Clk(clk), .Reset(rst), .bus(if1)
  );

  logic [1:0] rdy, dn, cen, oen, wen;
  logic [15:0] rd[2], ma[2], mwd[2];
  assign rdy = {if1.Ready, if0.Ready};
  assign dn = {if1.Done, if0.Done};
  assign cen = {if1.Mem_CE_N, if0.Mem_CE_N};
  assign oen = {if1.Mem_OE_N, if0.Mem_OE_N};
  assign wen = {if1.Mem_WE_N, if0.Mem_WE_N};
  assign rd[0] = if0.RData;
  assign rd[1] = if1.RData;
  assign ma[0] = if0.Mem_Addr;
  assign ma[1] = if1.Mem_Addr;
  assign mwd[0] = if0.Mem_WData;
  assign mwd[1] = if1.Mem_WData;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: p = edges since accept (accept edge gives p=1).
  // Access for p=1..W, write recovery at p=W+1, Done in the last phase.
  logic busy[2];
  logic mwe[2];
  int p[2];
  logic [15:0] mar[2], mdr[2];

  function automatic int wc(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int done_p(int d);
    return wc(d) + (mwe[d] ? 2 : 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        busy[d] <= 1'b0;
        p[d] <= 0;
        mwe[d] <= 1'b0;
        mar[d] <= '0;
        mdr[d] <= '0;
      end else if (!busy[d]) begin
        if (req) begin
          busy[d] <= 1'b1;
          p[d] <= 1;
          mwe[d] <= we;
          mar[d] <= addr;
          if (we) mdr[d] <= wdata;
        end
      end else begin
        if (!mwe[d] && p[d] == wc(d)) mdr[d] <= mrdata;
        if (p[d] == done_p(d)) begin
          busy[d] <= 1'b0;
          p[d] <= 0;
        end else begin
          p[d] <= p[d] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic acc, rec, dne;
        acc = busy[d] && p[d] <= wc(d);
        rec = busy[d] && mwe[d] && p[d] == wc(d) + 1;
        dne = busy[d] && p[d] == done_p(d);
        chk($sformatf("d%0d ready", d), rdy[d], !busy[d]);
        chk($sformatf("d%0d done", d), dn[d], dne);
        chk($sformatf("d%0d ce_n", d), cen[d], !(acc || rec));
        chk($sformatf("d%0d oe_n", d), oen[d], !(acc && !mwe[d]));
        chk($sformatf("d%0d we_n", d), wen[d], !(acc && mwe[d]));
        chk($sformatf("d%0d mem_addr", d), ma[d], mar[d]);
        chk($sformatf("d%0d rdata", d), rd[d], mdr[d]);
        chk($sformatf("d%0d mem_wdata", d), mwd[d], mdr[d]);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst ready", rdy[0], 1);
    chk("rst done", dn[0], 0);
    chk("rst strobes", {cen[0], oen[0], wen[0]}, 3'b111);
    chk("rst mem_addr", ma[0], 16'h0000);
    chk("rst rdata", rd[0], 16'h0000);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Read 0x0042 -> 0xBEEF
    #1 req = 1'b1; we = 1'b0; addr = 16'h0042; mrdata = 16'hBEEF;
    @(negedge clk);
    chk("rd a1 oe_n", oen[0], 0);
    chk("rd a1 ce_n", cen[0], 0);
    chk("rd a1 addr", ma[0], 16'h0042);
    chk("rd w1 oe_n", oen[1], 0);
    #1 req = 1'b0; addr = 16'h0000;
    @(negedge clk);
    chk("rd a2 oe_n", oen[0], 0);
    chk("rd w1 done", dn[1], 1);
    chk("rd w1 rdata", rd[1], 16'hBEEF);
    @(negedge clk);
    chk("rd done", dn[0], 1);
    chk("rd rdata", rd[0], 16'hBEEF);
    chk("rd done oe_n", oen[0], 1);
    repeat (3) @(negedge clk);

    // Write 0x1234 <- 0xA5A5
    #1 req = 1'b1; we = 1'b1; addr = 16'h1234; wdata = 16'hA5A5;
    @(negedge clk);
    chk("wr a1 we_n", wen[0], 0);
    chk("wr a1 oe_n", oen[0], 1);
    chk("wr a1 wdata", mwd[0], 16'hA5A5);
    #1 req = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    @(negedge clk);
    chk("wr a2 we_n", wen[0], 0);
    chk("wr a2 oe_n", oen[0], 1);
    @(negedge clk);
    chk("wr rec we_n", wen[0], 1);
    chk("wr rec ce_n", cen[0], 0);
    chk("wr rec wdata", mwd[0], 16'hA5A5);
    chk("wr rec done", dn[0], 0);
    @(negedge clk);
    chk("wr done", dn[0], 1);
    repeat (3) @(negedge clk);

    // Req held, address changed during ACCESS
    #1 req = 1'b1; we = 1'b0; addr = 16'h1111; mrdata = 16'h2222;
    @(negedge clk);
    chk("hold a1 addr", ma[0], 16'h1111);
    #1 addr = 16'hFFFF;
    @(negedge clk);
    chk("hold a2 addr", ma[0], 16'h1111);
    @(negedge clk);
    chk("hold done", dn[0], 1);
    chk("hold rdata", rd[0], 16'h2222);
    @(negedge clk);
    chk("hold idle ready", rdy[0], 1);
    @(negedge clk);
    chk("hold 2nd ready", rdy[0], 0);
    chk("hold 2nd addr", ma[0], 16'hFFFF);
    #1 req = 1'b0;
    repeat (5) @(negedge clk);

    // Reset during write ACCESS
    #1 req = 1'b1; we = 1'b1; addr = 16'h5555; wdata = 16'h0F0F;
    @(negedge clk);
    chk("abort a1 we_n", wen[0], 0);
    #1 req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort we_n", wen[0], 1);
    chk("abort ce_n", cen[0], 1);
    chk("abort ready", rdy[0], 1);
    chk("abort addr", ma[0], 16'h0000);
    chk("abort w1 done", dn[1], 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post rst ready", rdy[0], 1);
    chk("post rst done", dn, 2'b00);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
